reg_bank: RTL

- Parametrised multi-entry register bank; the next generation of the single-word enabled register.
- One write port and two registered read ports.
- Per-entry valid bits, write-first bypass, bulk clear, and a live occupancy count.
- Holds operands and intermediates inside a PE so the ALU, bus interface and neighbour links can share one storage block.

---
 rtl/reg_bank_pkg.sv | 21 ++
 rtl/reg_bank_entry.sv | 40 ++++
 rtl/reg_bank.sv | 134 +++++++++++++
 3 files changed

// File: rtl/reg_bank_pkg.sv
// Shared definitions for the PE register bank: address-width helper and
// default storage geometry.
package reg_bank_pkg;

    localparam int unsigned PE_LEN   = 16;
    localparam int unsigned PE_DEPTH = 8;

    localparam int unsigned MIN_DEPTH = 2;
    localparam int unsigned MAX_DEPTH = 256;

    // Smallest w such that 2^w >= n (returns 0 for n <= 1).
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/reg_bank_entry.sv
// One storage word plus its valid bit. A write always wins over clear so a
// same-cycle clear+write leaves exactly this entry valid.
module reg_bank_entry
    import reg_bank_pkg::*;
#(
    parameter int unsigned LEN = PE_LEN
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           i_we,
    input  logic           i_clr,
    input  logic [LEN-1:0] i_data,
    output logic [LEN-1:0] o_data,
    output logic           o_valid
);

    logic [LEN-1:0] r_data;
    logic           r_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else begin
            if (i_we) begin
                r_data <= i_data;
            end
            // clear only touches the valid bit; stale data stays in storage
            if (i_we) begin
                r_valid <= 1'b1;
            end else if (i_clr) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;

endmodule

// File: rtl/reg_bank.sv
// Multi-entry PE register bank: one write port, two registered read ports
// with write-first bypass, bulk clear and a live occupancy count.
module reg_bank
    import reg_bank_pkg::*;
#(
    parameter int unsigned LEN      = PE_LEN,
    parameter int unsigned DEPTH    = PE_DEPTH,
    parameter int unsigned ADDR_LEN = clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wrEn,
    input  logic [ADDR_LEN-1:0] wrAddr,
    input  logic [LEN-1:0]      dataIn,
    input  logic                clear,
    input  logic                rdEn0,
    input  logic [ADDR_LEN-1:0] rdAddr0,
    output logic [LEN-1:0]      rdData0,
    output logic                rdValid0,
    input  logic                rdEn1,
    input  logic [ADDR_LEN-1:0] rdAddr1,
    output logic [LEN-1:0]      rdData1,
    output logic                rdValid1,
    output logic [ADDR_LEN:0]   numValid
);

    localparam int unsigned MEM_SLOTS = 32'd1 << ADDR_LEN;
    localparam int unsigned CNT_W     = ADDR_LEN + 1;

    if (DEPTH < MIN_DEPTH || DEPTH > MAX_DEPTH) begin : g_bad_depth
        $error("reg_bank: DEPTH %0d outside %0d..%0d", DEPTH, MIN_DEPTH, MAX_DEPTH);
    end
    if (ADDR_LEN < clog2(DEPTH)) begin : g_bad_addr_len
        $error("reg_bank: ADDR_LEN %0d too narrow for DEPTH %0d", ADDR_LEN, DEPTH);
    end

    // Storage is padded to the full address space; pad slots read as invalid zero.
    logic [MEM_SLOTS-1:0][LEN-1:0] w_mem_data;
    logic [MEM_SLOTS-1:0]          w_mem_valid;

    logic w_wr_legal;
    logic w_fresh;
    logic w_byp0;
    logic w_byp1;
    logic [LEN:0] w_rd0;
    logic [LEN:0] w_rd1;

    logic [LEN-1:0] r_rd_data0;
    logic           r_rd_valid0;
    logic [LEN-1:0] r_rd_data1;
    logic           r_rd_valid1;
    logic [CNT_W-1:0] r_num_valid;

    assign w_wr_legal = wrEn && (32'(wrAddr) < DEPTH);
    assign w_fresh    = w_wr_legal && !w_mem_valid[wrAddr];
    assign w_byp0     = w_wr_legal && (rdAddr0 == wrAddr);
    assign w_byp1     = w_wr_legal && (rdAddr1 == wrAddr);

    for (genvar i = 0; i < MEM_SLOTS; i++) begin : g_slot
        if (32'(i) < DEPTH) begin : g_entry
            logic w_we;
            assign w_we = w_wr_legal && (wrAddr == ADDR_LEN'(i));

            reg_bank_entry #(
                .LEN (LEN)
            ) u_entry (
                .clk     (clk),
                .reset   (reset),
                .i_we    (w_we),
                .i_clr   (clear),
                .i_data  (dataIn),
                .o_data  (w_mem_data[i]),
                .o_valid (w_mem_valid[i])
            );
        end else begin : g_pad
            assign w_mem_data[i]  = '0;
            assign w_mem_valid[i] = 1'b0;
        end
    end

    // Returns {valid, data}; bypass beats storage, invalid entries read as zero.
    function automatic logic [LEN:0] read_port(
        input logic [ADDR_LEN-1:0]          addr,
        input logic                         byp,
        input logic [LEN-1:0]               byp_data,
        input logic [MEM_SLOTS-1:0][LEN-1:0] mem,
        input logic [MEM_SLOTS-1:0]         vld
    );
        if (byp) begin
            return {1'b1, byp_data};
        end
        if (vld[addr]) begin
            return {1'b1, mem[addr]};
        end
        return '0;
    endfunction

    assign w_rd0 = read_port(rdAddr0, w_byp0, dataIn, w_mem_data, w_mem_valid);
    assign w_rd1 = read_port(rdAddr1, w_byp1, dataIn, w_mem_data, w_mem_valid);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_data0  <= '0;
            r_rd_valid0 <= 1'b0;
            r_rd_data1  <= '0;
            r_rd_valid1 <= 1'b0;
        end else begin
            if (rdEn0) begin
                {r_rd_valid0, r_rd_data0} <= w_rd0;
            end
            if (rdEn1) begin
                {r_rd_valid1, r_rd_data1} <= w_rd1;
            end
        end
    end

    // Occupancy tracks the valid bits: clear drops to zero, then a legal write adds one.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_num_valid <= '0;
        end else if (clear) begin
            r_num_valid <= w_wr_legal ? CNT_W'(1) : '0;
        end else if (w_fresh) begin
            r_num_valid <= r_num_valid + CNT_W'(1);
        end
    end

    assign rdData0  = r_rd_data0;
    assign rdValid0 = r_rd_valid0;
    assign rdData1  = r_rd_data1;
    assign rdValid1 = r_rd_valid1;
    assign numValid = r_num_valid;

endmodule
